conv_requant_pack: RTL and testbench

- Downstream stage of the per-kernel channel accumulator.
- Takes the final 32-bit signed partial sums, one per output pixel, and applies per-output-channel bias, multiplier, rounding right-shift, optional ReLU and int8 saturation.
- Packs four int8 results into a 32-bit word for the feature-map write-back path.
- Tracks pixel and channel position internally and flags channel and frame ends.

---
 rtl/conv_requant_pack.sv | 204 ++++++++++++++++++++
 tb/tb_conv_requant_pack.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_requant_pack.sv
// Requantises final 32-bit accumulator values to int8 per output channel and packs
// four results per 32-bit word, tagging channel and frame boundaries.
module conv_requant_pack #(
    parameter int unsigned CH_AW    = 6,
    parameter int unsigned PIX_W    = 13,
    parameter int unsigned PIPE_LAT = 4
) (
    input  logic                sclk,
    input  logic                s_rst_n,
    input  logic [31:0]         acc_in,
    input  logic                acc_in_vld,
    input  logic [PIX_W-1:0]    cfg_pix_num,
    input  logic [CH_AW:0]      cfg_ch_num,
    input  logic                cfg_relu_en,
    input  logic                prm_wr_en,
    input  logic [CH_AW-1:0]    prm_wr_addr,
    input  logic [31:0]         prm_wr_bias,
    input  logic [15:0]         prm_wr_mult,
    input  logic [4:0]          prm_wr_shift,
    output logic [31:0]         out_data,
    output logic [3:0]          out_keep,
    output logic                out_vld,
    output logic                out_ch_last,
    output logic                frame_done
);

    localparam int unsigned DEPTH = 2 ** CH_AW;
    localparam int unsigned CHW   = CH_AW + 1;
    localparam int unsigned PW    = 49;
    localparam int unsigned LAST  = PIPE_LAT - 1;

    logic signed [31:0] bias_mem  [DEPTH];
    logic [15:0]        mult_mem  [DEPTH];
    logic [4:0]         shift_mem [DEPTH];

    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [CH_AW-1:0]    ch_cnt_q, ch_cnt_d;
    logic                last_pix_c, last_ch_c;

    logic [PIPE_LAT-1:0] vld_q, vld_d, lch_q, lch_d, lfr_q, lfr_d;
    logic signed [31:0]  acc_s1_q, acc_s1_d, bias_s1_q, bias_s1_d;
    logic [15:0]         mult_s1_q, mult_s1_d, mult_s2_q, mult_s2_d;
    logic [4:0]          shift_s1_q, shift_s1_d, shift_s2_q, shift_s2_d, shift_s3_q, shift_s3_d;
    logic signed [31:0]  sum_s2_q, sum_s2_d;
    logic signed [32:0]  sum_wide_c;
    logic signed [PW-1:0] prod_s3_q, prod_s3_d, rnd_c, r_c;
    logic [7:0]          q_s4_q, q_s4_d;

    logic [1:0]          lane_q, lane_d;
    logic [23:0]         pack_q, pack_d;
    logic [31:0]         word_c;
    logic [31:0]         out_data_q, out_data_d;
    logic [3:0]          out_keep_q, out_keep_d;
    logic                out_vld_q, out_vld_d, out_ch_last_q, out_ch_last_d, frame_done_q, frame_done_d;

    // Parameter table: plain register array, not reset, written one cycle ahead of use
    always_ff @(posedge sclk) begin
        if (prm_wr_en) begin
            bias_mem[prm_wr_addr]  <= prm_wr_bias;
            mult_mem[prm_wr_addr]  <= prm_wr_mult;
            shift_mem[prm_wr_addr] <= prm_wr_shift;
        end
    end

    assign last_pix_c = (pix_cnt_q == (cfg_pix_num - PIX_W'(1)));
    assign last_ch_c  = ({1'b0, ch_cnt_q} == (cfg_ch_num - CHW'(1)));

    // Pixel/channel position and the four arithmetic stages
    always_comb begin
        pix_cnt_d = pix_cnt_q;
        ch_cnt_d  = ch_cnt_q;
        if (acc_in_vld) begin
            if (last_pix_c) begin
                pix_cnt_d = '0;
                ch_cnt_d  = last_ch_c ? '0 : ch_cnt_q + CH_AW'(1);
            end else begin
                pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
        end

        vld_d = {vld_q[PIPE_LAT-2:0], acc_in_vld};
        lch_d = {lch_q[PIPE_LAT-2:0], last_pix_c};
        lfr_d = {lfr_q[PIPE_LAT-2:0], last_pix_c & last_ch_c};

        acc_s1_d   = acc_in;
        bias_s1_d  = bias_mem[ch_cnt_q];
        mult_s1_d  = mult_mem[ch_cnt_q];
        shift_s1_d = shift_mem[ch_cnt_q];

        sum_wide_c = 33'(acc_s1_q) + 33'(bias_s1_q);
        if (sum_wide_c[32] != sum_wide_c[31]) begin
            sum_s2_d = sum_wide_c[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end else begin
            sum_s2_d = sum_wide_c[31:0];
        end
        mult_s2_d  = mult_s1_q;
        shift_s2_d = shift_s1_q;

        prod_s3_d  = PW'(sum_s2_q) * PW'($signed({1'b0, mult_s2_q}));
        shift_s3_d = shift_s2_q;

        rnd_c = (shift_s3_q == 5'd0) ? '0 : (PW'(1) << (shift_s3_q - 5'd1));
        r_c   = (prod_s3_q + rnd_c) >>> shift_s3_q;
        if (cfg_relu_en && r_c[PW-1]) begin
            r_c = '0;
        end
        if (r_c > 49'sd127) begin
            q_s4_d = 8'h7F;
        end else if (r_c < -49'sd128) begin
            q_s4_d = 8'h80;
        end else begin
            q_s4_d = r_c[7:0];
        end
    end

    // Byte packer: flush on a full word or at the end of a channel
    always_comb begin
        lane_d        = lane_q;
        pack_d        = pack_q;
        out_data_d    = out_data_q;
        out_keep_d    = out_keep_q;
        out_vld_d     = 1'b0;
        out_ch_last_d = 1'b0;
        frame_done_d  = 1'b0;
        word_c        = {8'h00, pack_q};
        word_c[{lane_q, 3'b000} +: 8] = q_s4_q;
        if (vld_q[LAST]) begin
            if (lane_q == 2'd3 || lch_q[LAST]) begin
                out_data_d    = word_c;
                out_vld_d     = 1'b1;
                out_ch_last_d = lch_q[LAST];
                frame_done_d  = lfr_q[LAST];
                lane_d        = '0;
                pack_d        = '0;
                case (lane_q)
                    2'd0:    out_keep_d = 4'b0001;
                    2'd1:    out_keep_d = 4'b0011;
                    2'd2:    out_keep_d = 4'b0111;
                    default: out_keep_d = 4'b1111;
                endcase
            end else begin
                pack_d = word_c[23:0];
                lane_d = lane_q + 2'd1;
            end
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            pix_cnt_q     <= '0;
            ch_cnt_q      <= '0;
            vld_q         <= '0;
            lch_q         <= '0;
            lfr_q         <= '0;
            acc_s1_q      <= '0;
            bias_s1_q     <= '0;
            mult_s1_q     <= '0;
            shift_s1_q    <= '0;
            sum_s2_q      <= '0;
            mult_s2_q     <= '0;
            shift_s2_q    <= '0;
            prod_s3_q     <= '0;
            shift_s3_q    <= '0;
            q_s4_q        <= '0;
            lane_q        <= '0;
            pack_q        <= '0;
            out_data_q    <= '0;
            out_keep_q    <= '0;
            out_vld_q     <= 1'b0;
            out_ch_last_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            pix_cnt_q     <= pix_cnt_d;
            ch_cnt_q      <= ch_cnt_d;
            vld_q         <= vld_d;
            lch_q         <= lch_d;
            lfr_q         <= lfr_d;
            acc_s1_q      <= acc_s1_d;
            bias_s1_q     <= bias_s1_d;
            mult_s1_q     <= mult_s1_d;
            shift_s1_q    <= shift_s1_d;
            sum_s2_q      <= sum_s2_d;
            mult_s2_q     <= mult_s2_d;
            shift_s2_q    <= shift_s2_d;
            prod_s3_q     <= prod_s3_d;
            shift_s3_q    <= shift_s3_d;
            q_s4_q        <= q_s4_d;
            lane_q        <= lane_d;
            pack_q        <= pack_d;
            out_data_q    <= out_data_d;
            out_keep_q    <= out_keep_d;
            out_vld_q     <= out_vld_d;
            out_ch_last_q <= out_ch_last_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_keep    = out_keep_q;
    assign out_vld     = out_vld_q;
    assign out_ch_last = out_ch_last_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_conv_requant_pack.sv
// Scoreboard bench for conv_requant_pack: directed frames plus a gapped two-frame run.
module tb_conv_requant_pack;

    localparam int unsigned CH_AW = 6;
    localparam int unsigned PIX_W = 13;

    logic              sclk = 1'b0;
    logic              s_rst_n;
    logic [31:0]       acc_in;
    logic              acc_in_vld;
    logic [PIX_W-1:0]  cfg_pix_num;
    logic [CH_AW:0]    cfg_ch_num;
    logic              cfg_relu_en;
    logic              prm_wr_en;
    logic [CH_AW-1:0]  prm_wr_addr;
    logic [31:0]       prm_wr_bias;
    logic [15:0]       prm_wr_mult;
    logic [4:0]        prm_wr_shift;
    logic [31:0]       out_data;
    logic [3:0]        out_keep;
    logic              out_vld;
    logic              out_ch_last;
    logic              frame_done;

    conv_requant_pack #(.CH_AW(CH_AW), .PIX_W(PIX_W), .PIPE_LAT(4)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n),
        .acc_in(acc_in), .acc_in_vld(acc_in_vld),
        .cfg_pix_num(cfg_pix_num), .cfg_ch_num(cfg_ch_num), .cfg_relu_en(cfg_relu_en),
        .prm_wr_en(prm_wr_en), .prm_wr_addr(prm_wr_addr), .prm_wr_bias(prm_wr_bias),
        .prm_wr_mult(prm_wr_mult), .prm_wr_shift(prm_wr_shift),
        .out_data(out_data), .out_keep(out_keep), .out_vld(out_vld),
        .out_ch_last(out_ch_last), .frame_done(frame_done)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        chl;
        logic        fd;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // reference parameter copy and packer state for the gapped run
    int          mb[64];
    int          mm[64];
    int          ms[64];
    int          m_pix, m_ch, m_lane;
    logic [31:0] m_word;

    always @(posedge sclk) cyc <= cyc + 1;

    // Monitor: every presented word must match the head of the scoreboard
    always @(negedge sclk) begin
        if (s_rst_n && out_vld) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word got data=%h keep=%b chl=%b fd=%b", out_data, out_keep, out_ch_last, frame_done);
            end else begin
                mon_e = sbq.pop_front();
                checks++;
                if (out_data !== mon_e.data || out_keep !== mon_e.keep ||
                    out_ch_last !== mon_e.chl || frame_done !== mon_e.fd) begin
                    failures++;
                    $display("FAIL word got data=%h keep=%b chl=%b fd=%b want data=%h keep=%b chl=%b fd=%b",
                             out_data, out_keep, out_ch_last, frame_done, mon_e.data, mon_e.keep, mon_e.chl, mon_e.fd);
                end
                if (mon_e.cyc >= 0) begin
                    checks++;
                    if (cyc != mon_e.cyc) begin
                        failures++;
                        $display("FAIL latency got cycle=%0d want cycle=%0d", cyc, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic c, input logic f, input int at);
        exp_t e;
        e.data = d; e.keep = k; e.chl = c; e.fd = f; e.cyc = at;
        sbq.push_back(e);
    endtask

    task automatic pix(input int v);
        acc_in     = 32'(v);
        acc_in_vld = 1'b1;
        tick();
        acc_in_vld = 1'b0;
    endtask

    task automatic wr_prm(input int ch, input int b, input int m, input int s);
        prm_wr_en    = 1'b1;
        prm_wr_addr  = CH_AW'(ch);
        prm_wr_bias  = 32'(b);
        prm_wr_mult  = 16'(m);
        prm_wr_shift = 5'(s);
        mb[ch] = b; mm[ch] = m; ms[ch] = s;
        tick();
        prm_wr_en = 1'b0;
    endtask

    task automatic set_cfg(input int p, input int c, input logic r);
        cfg_pix_num = PIX_W'(p);
        cfg_ch_num  = 7'(c);
        cfg_relu_en = r;
        tick();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && sbq.size() > 0; i++) tick();
        repeat (3) tick();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain_%s got pending=%0d want pending=0", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({out_data, out_keep, out_vld, out_ch_last, frame_done} !== 39'd0) begin
            failures++;
            $display("FAIL idle_%s got data=%h keep=%b vld=%b chl=%b fd=%b want all zero",
                     name, out_data, out_keep, out_vld, out_ch_last, frame_done);
        end
    endtask

    // floor(x / 2**s) without relying on shift semantics
    function automatic longint floor_div(input longint x, input int s);
        longint d;
        d = longint'(64'd1 << s);
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic logic [7:0] ref_q(input int a, input int ch, input logic relu);
        longint s, p, r;
        s = longint'(a) + longint'(mb[ch]);
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        p = s * longint'(mm[ch]);
        r = (ms[ch] > 0) ? floor_div(p + longint'(64'd1 << (ms[ch] - 1)), ms[ch]) : p;
        if (relu && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return 8'(r);
    endfunction

    task automatic model_pix(input int a);
        logic lc, lf;
        m_word[m_lane*8 +: 8] = ref_q(a, m_ch, cfg_relu_en);
        lc = (m_pix == int'(cfg_pix_num) - 1);
        lf = lc && (m_ch == int'(cfg_ch_num) - 1);
        if (m_lane == 3 || lc) begin
            push(m_word, 4'((1 << (m_lane + 1)) - 1), lc, lf, -1);
            m_word = '0;
            m_lane = 0;
        end else begin
            m_lane++;
        end
        if (lc) begin
            m_pix = 0;
            m_ch  = lf ? 0 : m_ch + 1;
        end else begin
            m_pix++;
        end
    endtask

    initial begin
        int v;
        s_rst_n = 1'b0; acc_in = '0; acc_in_vld = 1'b0;
        cfg_pix_num = PIX_W'(4); cfg_ch_num = 7'd1; cfg_relu_en = 1'b0;
        prm_wr_en = 1'b0; prm_wr_addr = '0; prm_wr_bias = '0; prm_wr_mult = '0; prm_wr_shift = '0;
        repeat (3) tick();
        check_idle("reset");
        s_rst_n = 1'b1;
        tick();

        // basic: (100-5)*3=285, (285+2)>>2=71=0x47
        wr_prm(0, -5, 3, 2);
        set_cfg(4, 1, 1'b0);
        repeat (3) pix(100);
        push(32'h4747_4747, 4'b1111, 1'b1, 1'b1, cyc + 5);
        pix(100);
        drain("basic");

        // saturation and rounding across two channels
        wr_prm(0, 24, 1, 3);
        wr_prm(1, 0, 1, 3);
        set_cfg(2, 2, 1'b0);
        push(32'h0000_807F, 4'b0011, 1'b1, 1'b0, -1);
        push(32'h0000_0202, 4'b0011, 1'b1, 1'b1, -1);
        pix(1000); pix(-2000); pix(12); pix(12);
        drain("sat");

        // relu
        wr_prm(0, 0, 1, 0);
        set_cfg(2, 1, 1'b1);
        push(32'h0000_0700, 4'b0011, 1'b1, 1'b1, -1);
        pix(-7); pix(7);
        drain("relu");

        // partial flush: ch0 -> x+10, ch1 -> x-1
        wr_prm(0, 10, 2, 1);
        wr_prm(1, -1, 1, 0);
        set_cfg(6, 2, 1'b0);
        push(32'h0D0C_0B0A, 4'b1111, 1'b0, 1'b0, -1);
        push(32'h0000_0F0E, 4'b0011, 1'b1, 1'b0, -1);
        push(32'h0201_00FF, 4'b1111, 1'b0, 1'b0, -1);
        push(32'h0000_0403, 4'b0011, 1'b1, 1'b1, -1);
        for (int ch = 0; ch < 2; ch++)
            for (int i = 0; i < 6; i++) pix(i);
        drain("flush");

        // two gapped frames back to back against the reference model
        wr_prm(0, -300, 7, 4);
        wr_prm(1, 1000, 40000, 20);
        wr_prm(2, 0, 1, 0);
        set_cfg(5, 3, 1'b0);
        m_pix = 0; m_ch = 0; m_lane = 0; m_word = '0;
        for (int i = 0; i < 30; i++) begin
            v = (i % 7 == 3) ? int'($urandom) : int'($urandom_range(600)) - 300;
            model_pix(v);
            pix(v);
            repeat ($urandom_range(2)) tick();
        end
        drain("gaps");

        // reset mid-frame after three pixels, then a clean frame
        wr_prm(0, 0, 1, 0);
        wr_prm(1, 100, 1, 0);
        set_cfg(4, 2, 1'b0);
        pix(9); pix(9); pix(9);
        s_rst_n = 1'b0;
        tick();
        check_idle("midreset");
        tick();
        s_rst_n = 1'b1;
        repeat (8) tick();
        check_idle("postreset");
        push(32'h0403_0201, 4'b1111, 1'b1, 1'b0, -1);
        push(32'h6766_6564, 4'b1111, 1'b1, 1'b1, -1);
        pix(1); pix(2); pix(3); pix(4);
        pix(0); pix(1); pix(2); pix(3);
        drain("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
